// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU. It grants one operation at a time,
// runs it for one EXEC cycle, then holds the captured result until the owner takes it.
package CPU_package;
  localparam int unsigned ALU_DATA_WIDTH = 16;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOT = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7,
    ALU_CPR = 4'd8
  } enum_alu_opcode_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } struct_alu_flag_t;
endpackage

module alu_arbiter
  import CPU_package::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req0_carry,
  input  enum_alu_opcode_t      req0_opcode,
  input  logic                  req0_mode,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic                  req1_carry,
  input  enum_alu_opcode_t      req1_opcode,
  input  logic                  req1_mode,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output struct_alu_flag_t      rsp_flag,
  output logic [DATA_WIDTH-1:0] alu_in_a,
  output logic [DATA_WIDTH-1:0] alu_in_b,
  output logic                  alu_input_carry,
  output enum_alu_opcode_t      alu_opcode,
  output logic                  alu_mode,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  struct_alu_flag_t      alu_out_flag
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state, state_nxt;
  logic                 last_grant;
  logic                 owner;
  logic                 grant0, grant1;
  logic                 accept;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic                 op_carry;
  enum_alu_opcode_t     op_opcode;
  logic                 op_mode;

  assign alu_in_a        = op_a;
  assign alu_in_b        = op_b;
  assign alu_input_carry = op_carry;
  assign alu_opcode      = op_opcode;
  assign alu_mode        = op_mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_grant);
    grant1     = req1_valid && (!req0_valid || !last_grant);
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        // Readys are combinational, so they are masked while reset is held.
        req0_ready = grant0 && !rst;
        req1_ready = grant1 && !rst;
        if (grant0 || grant1) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        if (owner ? rsp1_ready : rsp0_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_carry   <= 1'b0;
      op_opcode  <= enum_alu_opcode_t'('0);
      op_mode    <= 1'b0;
      rsp_data   <= '0;
      rsp_flag   <= '0;
    end else begin
      if (accept) begin
        owner      <= grant1;
        last_grant <= grant1;
        op_a       <= grant1 ? req1_a      : req0_a;
        op_b       <= grant1 ? req1_b      : req0_b;
        op_carry   <= grant1 ? req1_carry  : req0_carry;
        op_opcode  <= grant1 ? req1_opcode : req0_opcode;
        op_mode    <= grant1 ? req1_mode   : req0_mode;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_flag <= alu_out_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the
// drive/return ports; expected results are hand-computed constants.
module tb_alu_arbiter;
  import CPU_package::*;

  localparam int unsigned DW = 16;

  logic                clk;
  logic                rst;
  logic                req_valid [2];
  logic                req_ready [2];
  logic                rsp_valid [2];
  logic                rsp_ready [2];
  logic [DW-1:0]       req0_a, req0_b, req1_a, req1_b;
  logic                req0_carry, req1_carry, req0_mode, req1_mode;
  enum_alu_opcode_t    req0_opcode, req1_opcode;
  logic [DW-1:0]       rsp_data;
  struct_alu_flag_t    rsp_flag;
  logic [DW-1:0]       alu_in_a, alu_in_b, alu_out;
  logic                alu_input_carry, alu_mode;
  enum_alu_opcode_t    alu_opcode;
  struct_alu_flag_t    alu_out_flag;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]),
    .req0_a(req0_a), .req0_b(req0_b), .req0_carry(req0_carry),
    .req0_opcode(req0_opcode), .req0_mode(req0_mode),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]),
    .req1_a(req1_a), .req1_b(req1_b), .req1_carry(req1_carry),
    .req1_opcode(req1_opcode), .req1_mode(req1_mode),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b),
    .alu_input_carry(alu_input_carry), .alu_opcode(alu_opcode), .alu_mode(alu_mode),
    .alu_out(alu_out), .alu_out_flag(alu_out_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPR returns a-b with carry set when no borrow occurs (a >= b).
  logic [DW:0] sum;
  logic        c_out;
  always_comb begin
    sum     = '0;
    c_out   = 1'b0;
    alu_out = '0;
    case (alu_opcode)
      ALU_ADD: begin
        sum     = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {{DW{1'b0}}, alu_input_carry};
        alu_out = sum[DW-1:0];
        c_out   = sum[DW];
      end
      ALU_AND: alu_out = alu_in_a & alu_in_b;
      ALU_SHL: alu_out = alu_in_a << 1;
      ALU_SHR: alu_out = alu_in_a >> 1;
      ALU_CPR: begin
        alu_out = alu_in_a - alu_in_b;
        c_out   = (alu_in_a >= alu_in_b);
      end
      default: alu_out = '0;
    endcase
    alu_out_flag.zero     = (alu_out == '0);
    alu_out_flag.carry    = c_out;
    alu_out_flag.negative = alu_out[DW-1];
    alu_out_flag.overflow = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int who, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input enum_alu_opcode_t op, input logic mode);
    if (who == 0) begin
      req0_a = a; req0_b = b; req0_carry = 1'b0; req0_opcode = op; req0_mode = mode;
    end else begin
      req1_a = a; req1_b = b; req1_carry = 1'b0; req1_opcode = op; req1_mode = mode;
    end
    req_valid[who] = 1'b1;
  endtask

  // Entered just after the negedge of the accept cycle; leaves just after the
  // negedge of the following IDLE cycle.
  task automatic serve(input int who, input logic [DW-1:0] exp_a, input enum_alu_opcode_t exp_op,
                       input logic exp_mode, input logic [DW-1:0] exp_data, input logic [3:0] exp_flag);
    @(negedge clk);
    req_valid[who] = 1'b0;
    #1;
    check("exec_rsp0_valid", rsp_valid[0], 0);
    check("exec_rsp1_valid", rsp_valid[1], 0);
    check("exec_req0_ready", req_ready[0], 0);
    check("exec_req1_ready", req_ready[1], 0);
    check("exec_alu_a", alu_in_a, exp_a);
    check("exec_alu_op", alu_opcode, exp_op);
    check("exec_alu_mode", alu_mode, exp_mode);
    @(negedge clk);
    #1;
    check("resp_owner_valid", rsp_valid[who], 1);
    check("resp_other_valid", rsp_valid[1-who], 0);
    check("resp_data", rsp_data, exp_data);
    check("resp_flag", rsp_flag, exp_flag);
    rsp_ready[who] = 1'b1;
    @(negedge clk);
    rsp_ready[who] = 1'b0;
    #1;
    check("done_owner_valid", rsp_valid[who], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      rsp_ready[i] = 1'b0;
    end
    req0_a = '0; req0_b = '0; req0_carry = 1'b0; req0_opcode = ALU_ADD; req0_mode = 1'b0;
    req1_a = '0; req1_b = '0; req1_carry = 1'b0; req1_opcode = ALU_ADD; req1_mode = 1'b0;

    #2 rst = 1'b1;
    req_valid[0] = 1'b1;
    #1;
    check("rst_req0_ready", req_ready[0], 0);
    check("rst_rsp0_valid", rsp_valid[0], 0);
    check("rst_rsp1_valid", rsp_valid[1], 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_flag", rsp_flag, 0);
    check("rst_alu_a", alu_in_a, 0);
    check("rst_alu_b", alu_in_b, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_alu_mode", alu_mode, 0);
    check("rst_alu_carry", alu_input_carry, 0);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single requester, accepted on the first edge after reset release.
    set_req(0, 16'd1, 16'd1, ALU_AND, 1'b0);
    #1;
    check("t1_req0_ready", req_ready[0], 1);
    check("t1_req1_ready", req_ready[1], 0);
    serve(0, 16'd1, ALU_AND, 1'b0, 16'd1, 4'b0000);

    // Fresh reset, then a tie: req0 first, req1 next, next tie to req0 again.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 16'd3, 16'd5, ALU_ADD, 1'b1);
    set_req(1, 16'd7, 16'd8, ALU_ADD, 1'b1);
    #1;
    check("tie1_req0_ready", req_ready[0], 1);
    check("tie1_req1_ready", req_ready[1], 0);
    serve(0, 16'd3, ALU_ADD, 1'b1, 16'd8, 4'b0000);
    check("after0_req1_ready", req_ready[1], 1);
    check("after0_req0_ready", req_ready[0], 0);
    serve(1, 16'd7, ALU_ADD, 1'b1, 16'd15, 4'b0000);
    set_req(0, 16'd3, 16'd5, ALU_ADD, 1'b1);
    set_req(1, 16'd7, 16'd8, ALU_ADD, 1'b1);
    #1;
    check("tie2_req0_ready", req_ready[0], 1);
    check("tie2_req1_ready", req_ready[1], 0);
    serve(0, 16'd3, ALU_ADD, 1'b1, 16'd8, 4'b0000);

    // req1 is still pending: accept it and hold its response under backpressure.
    check("bp_req1_ready", req_ready[1], 1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    set_req(0, 16'd20, 16'd10, ALU_CPR, 1'b0);
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_rsp1_valid", rsp_valid[1], 1);
      check("bp_rsp0_valid", rsp_valid[0], 0);
      check("bp_rsp_data", rsp_data, 16'd15);
      check("bp_req0_ready", req_ready[0], 0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    #1;
    check("bp_done_rsp1_valid", rsp_valid[1], 0);
    check("cpr_req0_ready", req_ready[0], 1);

    // Operands change during EXEC; the latched values must be used.
    @(negedge clk);
    req_valid[0] = 1'b0;
    req0_a = '0;
    req0_b = 16'd99;
    #1;
    check("cpr_alu_a", alu_in_a, 16'd20);
    check("cpr_alu_b", alu_in_b, 16'd10);
    @(negedge clk);
    #1;
    check("cpr_rsp0_valid", rsp_valid[0], 1);
    check("cpr_rsp_data", rsp_data, 16'd10);
    check("cpr_rsp_flag", rsp_flag, 4'b0100);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;

    // Reset asserted mid-EXEC wipes the operation.
    set_req(0, 16'd9, 16'd9, ALU_ADD, 1'b0);
    #1;
    check("rx_req0_ready", req_ready[0], 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rx_req0_ready_rst", req_ready[0], 0);
    check("rx_rsp0_valid_rst", rsp_valid[0], 0);
    check("rx_rsp_data_rst", rsp_data, 0);
    check("rx_rsp_flag_rst", rsp_flag, 0);
    check("rx_alu_a_rst", alu_in_a, 0);
    check("rx_alu_op_rst", alu_opcode, 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rx_no_rsp0", rsp_valid[0], 0);
      check("rx_no_rsp1", rsp_valid[1], 0);
    end

    // Shifts after reset recovery.
    set_req(0, 16'd4, 16'd0, ALU_SHR, 1'b1);
    #1;
    check("shr_req0_ready", req_ready[0], 1);
    serve(0, 16'd4, ALU_SHR, 1'b1, 16'd2, 4'b0000);
    set_req(0, 16'd4, 16'd0, ALU_SHL, 1'b1);
    #1;
    check("shl_req0_ready", req_ready[0], 1);
    serve(0, 16'd4, ALU_SHL, 1'b1, 16'd8, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16 (CPU_package value), operand/result width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  DATA_WIDTH  operands.
REQ-007 reqN_carry  input  1  carry-in.
REQ-008 reqN_opcode  input  enum_alu_opcode_t  ALU operation.
REQ-009 reqN_mode  input  1  ALU mode select.
REQ-010 rspN_valid  output  1  result for requester N available.
REQ-011 rspN_ready  input  1  requester N consumes result.
REQ-012 rsp_data  output  DATA_WIDTH  captured ALU result, shared by both responders.
REQ-013 rsp_flag  output  struct_alu_flag_t  captured ALU flags.
REQ-014 alu_in_a, alu_in_b  output  DATA_WIDTH  to ALU operands.
REQ-015 alu_input_carry  output  1; alu_opcode  output  enum_alu_opcode_t; alu_mode  output  1  to ALU controls.
REQ-016 alu_out  input  DATA_WIDTH; alu_out_flag  input  struct_alu_flag_t  from ALU.

Function
REQ-017 States SHALL be IDLE, EXEC, RESP; one operation in flight at most.
REQ-018 IDLE: reqN_ready SHALL be 1 only for the arbitration winner, combinationally from reqN_valid and priority; both readys 0 outside IDLE.
REQ-019 Arbitration: single valid requester wins; both valid -> requester not granted last wins (round-robin).
REQ-020 Accept (valid & ready in IDLE): latch a, b, carry, opcode, mode and owner index; next state EXEC; last_grant <= owner.
REQ-021 ALU drive outputs SHALL always reflect latched operand registers, never live request inputs.
REQ-022 EXEC lasts exactly one cycle; at its end rsp_data <= alu_out, rsp_flag <= alu_out_flag; next state RESP.
REQ-023 RESP: rspN_valid = 1 only for owner; rsp_data/rsp_flag stable until handshake.
REQ-024 RESP with owner's rspN_ready = 1 -> IDLE next cycle; otherwise hold RESP indefinitely; non-owner rspN_ready ignored.
REQ-025 Latency accept -> rspN_valid = 2 cycles; back-to-back peak throughput 1 operation per 3 cycles.
REQ-026 Request inputs changing or deasserting outside the accept cycle SHALL not affect an in-flight operation.
REQ-027 Requests arriving in EXEC/RESP wait (ready 0); no queuing beyond the requester's own hold.

Reset
REQ-028 rst asserted SHALL immediately force IDLE, last_grant=1 (req0 wins first tie), all latched operands/opcode/mode/carry=0, rsp_data=0, rsp_flag=0, all readys and rspN_valid=0.
REQ-029 Reset during EXEC or RESP SHALL discard the operation; no response is produced after release.
REQ-030 First acceptance possible on the first rising edge after rst deasserts.

Verification
REQ-031 req0 only: a=1, b=1, AND, mode 0 -> req0_ready in IDLE, rsp0_valid 2 cycles later, rsp_data=1, rsp1_valid never 1.
REQ-032 Both valid same cycle after reset: req0 ADD mode 1 a=3 b=5; req1 ADD mode 1 a=7 b=8 -> req0 served first (rsp_data=8), then req1 (rsp_data=15); next tie grants req0 again.
REQ-033 Backpressure: rsp1_ready held 0 for 10 cycles in RESP -> rsp1_valid and rsp_data stable, req0_ready stays 0, completion on first rsp1_ready=1.
REQ-034 Operand change: after acceptance of a=20, b=10 CPR, drive req0_a=0 in EXEC -> alu_in_a stays 20, result/flags match CPR of 20 vs 10.
REQ-035 Reset mid-EXEC: assert rst during EXEC -> all outputs 0 asynchronously, no rspN_valid after release, next request accepted normally.
REQ-036 Shift: a=4, SHR mode 1 then SHL mode 1 -> rsp_data 2 then 8.
